// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_arbiter
// Description : Round-robin arbiter that shares one single-port, write-masked
//               SRAM-style memory between PORTS requesters. One registered
//               request slot sits in front of the memory and is presented
//               until the memory accepts it. The one-cycle-late read data or
//               write acknowledge is routed back to the issuing requester.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i            rising-edge clock
//   rst_ni           synchronous active-low reset
//   req_valid_i      per-port request valid                  [PORTS]
//   req_write_i      per-port write flag (1 = write)         [PORTS]
//   req_addr_i       per-port address, port p at [p*ADDR +: ADDR]
//   req_data_i       per-port write data, port p at [p*WIDTH +: WIDTH]
//   req_mask_i       per-port write mask, port p at [p*MASK +: MASK]
//   req_ready_o      one-hot grant                           [PORTS]
//   rsp_valid_o      one-hot completion pulse                [PORTS]
//   rsp_data_o       shared read data, zero unless a read completes
//   mem_enable_o     memory access valid
//   mem_isWrite_o    memory write flag
//   mem_writeMask_o  memory write mask
//   mem_wrData_o     memory write data, zero for reads
//   mem_addr_o       memory address
//   mem_rdData_i     memory read data, valid the cycle after acceptance
//   mem_hold_i       memory stall; presented access not taken while high
// ============================================================================
module mem_rr_arbiter #(
    parameter int PORTS  = 2,
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int MASK   = 4,
    parameter int ADDR   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [PORTS-1:0]       req_valid_i,
    input  logic [PORTS-1:0]       req_write_i,
    input  logic [PORTS*ADDR-1:0]  req_addr_i,
    input  logic [PORTS*WIDTH-1:0] req_data_i,
    input  logic [PORTS*MASK-1:0]  req_mask_i,
    output logic [PORTS-1:0]       req_ready_o,
    output logic [PORTS-1:0]       rsp_valid_o,
    output logic [WIDTH-1:0]       rsp_data_o,
    output logic                   mem_enable_o,
    output logic                   mem_isWrite_o,
    output logic [MASK-1:0]        mem_writeMask_o,
    output logic [WIDTH-1:0]       mem_wrData_o,
    output logic [ADDR-1:0]        mem_addr_o,
    input  logic [WIDTH-1:0]       mem_rdData_i,
    input  logic                   mem_hold_i
);

    // Port index width; PORTS >= 2 so this is at least 1.
    localparam int                c_PW      = $clog2(PORTS);
    localparam logic [c_PW-1:0]   c_LAST    = c_PW'(PORTS - 1);
    localparam logic [c_PW:0]     c_PORTS_W = (c_PW + 1)'(PORTS);
    localparam logic [PORTS-1:0]  c_ONE     = {{(PORTS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic              r_busy;
    logic [c_PW-1:0]   r_owner;
    logic              r_write;
    logic [ADDR-1:0]   r_addr;
    logic [WIDTH-1:0]  r_data;
    logic [MASK-1:0]   r_mask;
    logic [c_PW-1:0]   r_rr_ptr;
    logic              r_rsp_pend;
    logic [c_PW-1:0]   r_rsp_owner;
    logic              r_rsp_write;

    // ------------------------------------------------------------------------
    // Slot handshake
    // ------------------------------------------------------------------------
    logic w_mem_accept;
    logic w_slot_free;

    assign w_mem_accept = r_busy & ~mem_hold_i;
    // A slot being drained this cycle can be refilled in the same cycle,
    // which is what allows one grant per cycle when the memory never stalls.
    assign w_slot_free  = ~r_busy | w_mem_accept;

    // ------------------------------------------------------------------------
    // Round-robin search
    // The valid vector is duplicated and rotated right by the pointer so that
    // a plain lowest-index priority scan over the low PORTS bits visits the
    // ports in the order rr_ptr, rr_ptr+1, ... with wrap-around.
    // ------------------------------------------------------------------------
    logic [2*PORTS-1:0] w_rot;
    logic               w_found;
    logic [c_PW:0]      w_sum;
    logic [c_PW-1:0]    w_winner;
    logic               w_grant;

    assign w_rot = {req_valid_i, req_valid_i} >> r_rr_ptr;

    always_comb begin
        w_found  = 1'b0;
        w_sum    = '0;
        w_winner = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (c_PW + 1)'(k);
                // Rotation offset plus pointer can exceed PORTS-1 once;
                // fold it back so non-power-of-two PORTS also work.
                if (w_sum >= c_PORTS_W) begin
                    w_sum = w_sum - c_PORTS_W;
                end
                w_winner = w_sum[c_PW-1:0];
            end
        end
    end

    // Reset is synchronous, but the grant is masked while it is asserted so no
    // requester believes it was accepted during the reset cycle.
    assign w_grant     = rst_ni & w_slot_free & w_found;
    assign req_ready_o = w_grant ? (c_ONE << w_winner) : '0;

    // ------------------------------------------------------------------------
    // Winner field select
    // ------------------------------------------------------------------------
    logic              w_sel_write;
    logic [ADDR-1:0]   w_sel_addr;
    logic [WIDTH-1:0]  w_sel_data;
    logic [MASK-1:0]   w_sel_mask;

    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        w_sel_mask  = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (c_PW'(k) == w_winner) begin
                w_sel_write = req_write_i[k];
                w_sel_addr  = req_addr_i[k*ADDR +: ADDR];
                w_sel_data  = req_data_i[k*WIDTH +: WIDTH];
                w_sel_mask  = req_mask_i[k*MASK +: MASK];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Request slot and round-robin pointer
    // With no grant and no acceptance the slot simply keeps its value, which
    // holds every memory output steady across a stall.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_busy   <= 1'b0;
            r_owner  <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_mask   <= '0;
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_busy   <= 1'b1;
            r_owner  <= w_winner;
            r_write  <= w_sel_write;
            r_addr   <= w_sel_addr;
            r_data   <= w_sel_data;
            r_mask   <= w_sel_mask;
            r_rr_ptr <= (w_winner == c_LAST) ? '0 : w_winner + 1'b1;
        end else if (w_mem_accept) begin
            r_busy   <= 1'b0;
            r_owner  <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_mask   <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Response stage: captures who owned the access the memory just took, so
    // the slot is free to be refilled by the same or another port.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rsp_pend  <= 1'b0;
            r_rsp_owner <= '0;
            r_rsp_write <= 1'b0;
        end else if (w_mem_accept) begin
            r_rsp_pend  <= 1'b1;
            r_rsp_owner <= r_owner;
            r_rsp_write <= r_write;
        end else begin
            r_rsp_pend  <= 1'b0;
            r_rsp_owner <= '0;
            r_rsp_write <= 1'b0;
        end
    end

    assign rsp_valid_o = r_rsp_pend ? (c_ONE << r_rsp_owner) : '0;
    assign rsp_data_o  = (r_rsp_pend && !r_rsp_write) ? mem_rdData_i : '0;

    // ------------------------------------------------------------------------
    // Memory interface, driven straight from the slot
    // ------------------------------------------------------------------------
    assign mem_enable_o    = r_busy;
    assign mem_isWrite_o   = r_write;
    assign mem_writeMask_o = r_mask;
    assign mem_wrData_o    = r_write ? r_data : '0;
    assign mem_addr_o      = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_rr_arbiter
// Description : Self-checking bench for mem_rr_arbiter (PORTS=3). Acts as the
//               memory itself and keeps a transaction-level model of the
//               arbiter; directed scenarios are followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_rr_arbiter;

    localparam int P = 3;
    localparam int W = 16;
    localparam int H = 16;
    localparam int M = 4;
    localparam int A = 4;
    localparam int L = W / M;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [P-1:0]     req_valid, req_write, req_ready, rsp_valid;
    logic [P*A-1:0]   req_addr;
    logic [P*W-1:0]   req_data;
    logic [P*M-1:0]   req_mask;
    logic [W-1:0]     rsp_data, mem_wrData, mem_rdData;
    logic             mem_enable, mem_isWrite, mem_hold;
    logic [M-1:0]     mem_writeMask;
    logic [A-1:0]     mem_addr;

    // Per-port stimulus
    logic [P-1:0]     s_valid, s_write;
    logic [A-1:0]     s_addr [P];
    logic [W-1:0]     s_data [P];
    logic [M-1:0]     s_mask [P];

    always_comb begin
        req_valid = s_valid;
        req_write = s_write;
        req_addr  = '0;
        req_data  = '0;
        req_mask  = '0;
        for (int p = 0; p < P; p++) begin
            req_addr[p*A +: A] = s_addr[p];
            req_data[p*W +: W] = s_data[p];
            req_mask[p*M +: M] = s_mask[p];
        end
    end

    mem_rr_arbiter #(.PORTS(P), .WIDTH(W), .HEIGHT(H), .MASK(M)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_write_i     (req_write),
        .req_addr_i      (req_addr),
        .req_data_i      (req_data),
        .req_mask_i      (req_mask),
        .req_ready_o     (req_ready),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .mem_enable_o    (mem_enable),
        .mem_isWrite_o   (mem_isWrite),
        .mem_writeMask_o (mem_writeMask),
        .mem_wrData_o    (mem_wrData),
        .mem_addr_o      (mem_addr),
        .mem_rdData_i    (mem_rdData),
        .mem_hold_i      (mem_hold)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level model: one outstanding access, one pending response
    int          m_ptr = 0;
    bit          m_busy = 0;
    int          m_owner = 0;
    bit          m_write = 0;
    logic [A-1:0] m_addr = '0;
    logic [W-1:0] m_data = '0;
    logic [M-1:0] m_mask = '0;
    bit          m_pend = 0;
    int          m_rowner = 0;
    bit          m_rwrite = 0;
    logic [W-1:0] m_rdata = '0;
    bit          m_rd_next = 0;
    logic [W-1:0] tmem [H];
    int          g_win = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [P-1:0] v, input int ptr);
        for (int k = 0; k < P; k++) begin
            if (v[(ptr + k) % P]) return (ptr + k) % P;
        end
        return -1;
    endfunction

    // Compare every DUT output against the model at mid-cycle.
    task automatic step();
        logic [P-1:0] er, ev;
        @(negedge clk);
        er = '0;
        ev = '0;
        g_win = -1;
        if (rst_n && (!m_busy || !mem_hold)) g_win = pick(s_valid, m_ptr);
        if (g_win >= 0) er[g_win] = 1'b1;
        if (m_pend) ev[m_rowner] = 1'b1;
        chk("ready",   req_ready, er);
        chk("mem_en",  mem_enable, m_busy);
        chk("mem_wr",  mem_isWrite, m_write);
        chk("mem_msk", mem_writeMask, m_mask);
        chk("mem_wd",  mem_wrData, m_write ? m_data : '0);
        chk("mem_adr", mem_addr, m_addr);
        chk("rsp_v",   rsp_valid, ev);
        chk("rsp_d",   rsp_data, (m_pend && !m_rwrite) ? m_rdata : '0);
    endtask

    // Advance the model by one clock and act as the memory.
    task automatic adv();
        bit acc;
        acc = m_busy && !mem_hold;
        if (!rst_n) begin
            m_ptr = 0; m_busy = 0; m_owner = 0; m_write = 0;
            m_addr = '0; m_data = '0; m_mask = '0;
            m_pend = 0; m_rowner = 0; m_rwrite = 0; m_rd_next = 0;
        end else begin
            m_rd_next = 0;
            if (acc) begin
                if (m_write) begin
                    for (int b = 0; b < M; b++)
                        if (m_mask[b]) tmem[m_addr][b*L +: L] = m_data[b*L +: L];
                end else begin
                    m_rdata   = tmem[m_addr];
                    m_rd_next = 1;
                end
            end
            m_pend   = acc;
            m_rowner = m_owner;
            m_rwrite = m_write;
            if (g_win >= 0) begin
                m_busy  = 1;
                m_owner = g_win;
                m_write = s_write[g_win];
                m_addr  = s_addr[g_win];
                m_data  = s_data[g_win];
                m_mask  = s_mask[g_win];
                m_ptr   = (g_win + 1) % P;
            end else if (acc) begin
                m_busy = 0; m_owner = 0; m_write = 0;
                m_addr = '0; m_data = '0; m_mask = '0;
            end
        end
        @(posedge clk);
        #1;
        // Garbage on the read bus whenever no read is completing
        mem_rdData = m_rd_next ? m_rdata : W'($urandom);
    endtask

    task automatic tick();
        step();
        adv();
    endtask

    task automatic setp(input int p, input bit w, input logic [A-1:0] a,
                        input logic [W-1:0] d, input logic [M-1:0] m);
        s_write[p] = w;
        s_addr[p]  = a;
        s_data[p]  = d;
        s_mask[p]  = m;
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_hold   = 1'b0;
        mem_rdData = '0;
        s_valid    = '0;
        s_write    = '0;
        for (int p = 0; p < P; p++) setp(p, 0, '0, '0, '0);
        for (int i = 0; i < H; i++) tmem[i] = W'(i * 16'h0101);
        @(posedge clk);
        #1;

        // Reset state
        step();
        chk("rst_en", mem_enable, 1'b0);
        chk("rst_rdy", req_ready, 3'b000);
        chk("rst_rsp", rsp_valid, 3'b000);
        adv();
        rst_n = 1'b1;

        // Single read by port 1
        tmem[3] = 16'hBEEF;
        setp(1, 0, 4'd3, 16'h5555, 4'hF);
        s_valid = 3'b010;
        step(); chk("rd_grant", req_ready, 3'b010); adv();
        s_valid = 3'b000;
        step(); chk("rd_en", mem_enable, 1'b1); chk("rd_addr", mem_addr, 4'd3); adv();
        step(); chk("rd_rspv", rsp_valid, 3'b010); chk("rd_data", rsp_data, 16'hBEEF); adv();

        // Wrap-around: pointer is now 2, only port 0 valid
        setp(0, 0, 4'd1, 16'h0, 4'h0);
        s_valid = 3'b001;
        step(); chk("wrap_grant", req_ready, 3'b001); adv();
        s_valid = 3'b111;
        step(); chk("wrap_ptr", req_ready, 3'b010); adv();
        s_valid = 3'b000;
        tick(); tick();

        // Fairness from a fresh reset
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int p = 0; p < P; p++) setp(p, 0, A'(p + 8), 16'h0, 4'h0);
        s_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("fair_grant", req_ready, 3'b001 << (c % 3));
            if (c >= 2) chk("fair_rsp", rsp_valid, 3'b001 << ((c - 2) % 3));
            adv();
        end
        s_valid = 3'b000;
        tick(); tick();

        // Hold on a port 0 write
        setp(0, 1, 4'd5, 16'h1234, 4'b0011);
        s_valid = 3'b001;
        step(); chk("hold_grant", req_ready, 3'b001); adv();
        s_valid  = 3'b111;
        mem_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("hold_rdy", req_ready, 3'b000);
            chk("hold_en", mem_enable, 1'b1);
            chk("hold_adr", mem_addr, 4'd5);
            chk("hold_wd", mem_wrData, 16'h1234);
            chk("hold_msk", mem_writeMask, 4'b0011);
            adv();
        end
        mem_hold = 1'b0;
        s_valid  = 3'b000;
        tick();
        step(); chk("hold_rspv", rsp_valid, 3'b001); chk("hold_rspd", rsp_data, 16'h0); adv();
        tick();

        // Reset while busy and stalled (pointer is 1, so port 2 wins)
        setp(2, 0, 4'd7, 16'h0, 4'h0);
        s_valid = 3'b100;
        tick();
        s_valid  = 3'b000;
        mem_hold = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        s_valid  = 3'b111;
        step();
        chk("mrst_en", mem_enable, 1'b0);
        chk("mrst_rsp", rsp_valid, 3'b000);
        chk("mrst_grant", req_ready, 3'b001);
        adv();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n    = ($urandom_range(99) != 0);
            mem_hold = ($urandom_range(3) == 0);
            s_valid  = P'($urandom);
            for (int p = 0; p < P; p++)
                setp(p, 1'($urandom), A'($urandom), W'($urandom), M'($urandom));
            tick();
        end
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        s_valid  = '0;
        tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one single-port, write-masked SRAM-style memory between PORTS requesters using round-robin arbitration.
- It holds one registered request slot in front of the memory and presents it until the memory accepts it (mem_hold_i low). It then routes the one-cycle-late read data or write acknowledge back to the requester that issued the access.
- It sits between the client agents and the memory macro or memory driver.

Parameters:
- PORTS, 2: number of requesters; any value >= 2, not required to be a power of two.
- WIDTH, 16: data width in bits.
- HEIGHT, 16: number of memory words; address width is ADDR = $clog2(HEIGHT).
- MASK, 4: number of write-mask bits.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  reset: one clock; reset is synchronous and active-low.
- req_valid_i  in  PORTS  per-port request valid.
- req_write_i  in  PORTS  per-port write flag (1 = write, 0 = read).
- req_addr_i  in  PORTS*ADDR  per-port address; port p occupies bits [p*ADDR +: ADDR].
- req_data_i  in  PORTS*WIDTH  per-port write data.
- req_mask_i  in  PORTS*MASK  per-port write mask.
- req_ready_o  out  PORTS  one-hot grant; a request is accepted in the cycle where req_valid_i[p] and req_ready_o[p] are both high.
- rsp_valid_o  out  PORTS  one-hot completion pulse, one cycle long.
- rsp_data_o  out  WIDTH  read data, shared by all ports; qualified by rsp_valid_o.
- mem_enable_o  out  1  memory access valid.
- mem_isWrite_o  out  1  write flag.
- mem_writeMask_o  out  MASK  write mask.
- mem_wrData_o  out  WIDTH  write data; forced to 0 on reads.
- mem_addr_o  out  ADDR  address.
- mem_rdData_i  in  WIDTH  read data, valid the cycle after memory acceptance.
- mem_hold_i  in  1  memory stall; the presented access is not taken while this is high.

Behaviour:
- Slot register: fields busy, owner, write, addr, data, mask.
- Memory outputs are driven directly from the slot: mem_enable_o = busy.
- Memory acceptance: mem_accept = busy & ~mem_hold_i.
- slot_free = ~busy | mem_accept. Requests can therefore be accepted back-to-back, one per cycle, when there is no hold.
- Arbitration runs combinationally each cycle while slot_free is high:
  - The winner is the first p with req_valid_i[p] set, searching from rr_ptr upward and wrapping PORTS-1 -> 0.
  - req_ready_o[winner] = 1; all other bits are 0.
  - When slot_free is low, or no port is valid, req_ready_o = 0.
- On a grant, the next-state values are:
  - the slot loads the winner's fields and owner = winner, with busy = 1;
  - rr_ptr = winner+1, wrapping to 0 when winner = PORTS-1.
- On mem_accept with no new grant, busy becomes 0 and all slot fields are cleared to 0.
- rr_ptr does not move when there is no grant.
- While mem_hold_i is high and busy is high, every slot field is held stable. No memory output may change.
- Response stage:
  - On mem_accept, the block registers rsp_pend = 1, rsp_owner = owner and rsp_isWrite = write.
  - The following cycle, rsp_valid_o[rsp_owner] = 1 for exactly one cycle, for both reads and writes.
  - rsp_data_o = mem_rdData_i for reads and 0 for writes. When no response is pending, rsp_data_o is 0.
- Latency without hold: grant in cycle t -> mem_enable_o in t+1 -> rsp_valid_o in t+2. Each cycle of mem_hold_i adds one cycle.
- Requesters must keep their fields stable only until they are granted. The slot decouples the memory from the requester after the grant.
- Reset (rst_ni = 0, sampled on the clock edge) gives:
  - busy = 0, all slot fields = 0, rr_ptr = 0, rsp_pend = 0;
  - all outputs 0, and req_ready_o forced to 0.
- Reset asserted mid-operation drops any slot content and any pending response, with no completion pulse. The first grant after reset favours port 0.
- Simultaneous events:
  - grant and mem_accept in the same cycle: the slot is refilled and busy stays 1;
  - mem_accept with a new grant for the same port: that port receives rsp_valid_o for the old access while its new access is already presented.

Test Plan:
- Single read, PORTS=2: the memory contains 0xBEEF at addr 3; port 1 reads addr 3 with hold low. Required: req_ready_o = 2'b10 at t, mem_enable_o and mem_addr_o = 3 at t+1, rsp_valid_o = 2'b10 with rsp_data_o = 0xBEEF at t+2.
- Fairness, PORTS=3: all ports hold valid continuously. Required: grant order 0,1,2,0,1,2 with one grant per cycle, and rsp_valid_o following two cycles behind each grant.
- Hold: a port 0 write (addr 5, data 0x1234, mask 4'b0011) meets mem_hold_i high for 3 cycles. Required: all mem_* outputs stay constant for 3 cycles, req_ready_o = 0 throughout, the completion pulse for port 0 arrives with rsp_data_o = 0, and mem_wrData_o is 0 on any read.
- Wrap-around: rr_ptr = 2 with only port 0 valid. Required: port 0 is granted and rr_ptr = 1 afterwards.
- Reset mid-access: assert rst_ni = 0 while busy with hold high. Required: the next cycle has mem_enable_o = 0 and no rsp_valid_o; after release, port 0 wins the first grant when all ports are valid.
